// File: rtl/calc_seq_pkg.sv
// Shared types for the calculator command arbiter/sequencer.
// Holds the requester op encodings, the idle (hold) code driven to the
// calculator and the sequencer state enum.
package calc_seq_pkg;

  localparam int unsigned CALC_CODE_W = 3;
  localparam int unsigned REQ_N       = 2;

  // Invalid calculator code: calculator keeps accumulator and output.
  localparam logic [CALC_CODE_W-1:0] HOLD_CODE_DEF = 3'b111;

  typedef enum logic [1:0] {
    OP_SHOW_IN  = 2'd0,
    OP_ADD      = 2'd1,
    OP_SUB      = 2'd2,
    OP_SHOW_ACC = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Display ops return a result; arithmetic ops do not.
  function automatic logic op_has_rsp(input calc_op_e op);
    return (op == OP_SHOW_IN) || (op == OP_SHOW_ACC);
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Two-way arbiter producing a one-hot grant while grant_en is high.
// Macro CALC_SEQ_RR_EN: defined -> round-robin (pointer flips to the other
// requester after each grant); undefined -> fixed priority, requester 0 wins.
// Ports:
//   clk, rst_n   : clock, async active-low reset (pointer only)
//   req          : request vector
//   grant_en     : arbitration allowed this cycle
//   grant_c      : one-hot grant (combinational)
module calc_rr_arbiter
  import calc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic             grant_en,
  output logic [REQ_N-1:0] grant_c
);

`ifdef CALC_SEQ_RR_EN
  // prio_q = 1 favours requester 1; reset favours requester 0.
  logic prio_q, prio_d;

  always_comb begin
    grant_c = '0;
    prio_d  = prio_q;
    if (grant_en) begin
      unique case (req)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = prio_q ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
    // Pointer moves only on a grant: after granting 0, favour 1 and vice versa.
    if (|grant_c) prio_d = grant_c[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`else
  // Fixed priority has no state; clock and reset are intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    grant_c = '0;
    if (grant_en) begin
      if (req[0])      grant_c = 2'b01;
      else if (req[1]) grant_c = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/calc_seq_arbiter.sv
// Command arbiter and sequencer for the shared accumulator calculator.
// Accepts one (op, operand) command at a time from two requesters, drives the
// calculator code/operand for exactly one cycle, and for display ops returns
// the calculator's registered output to the issuing requester.
// Arbitration mode selected by macro CALC_SEQ_RR_EN (see calc_rr_arbiter).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester command handshake
//   req_op0/1, req_data0/1: command op and operand
//   rsp_valid/ready/data/id: result handshake, data and issuing requester
//   busy                  : high outside IDLE
//   calc_entrada/codigo   : calculator operand and op code
//   calc_saida            : calculator registered output
module calc_seq_arbiter
  import calc_seq_pkg::*;
#(
  parameter int unsigned            DATA_W    = 8,
  parameter logic [CALC_CODE_W-1:0] HOLD_CODE = HOLD_CODE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REQ_N-1:0]       req_valid,
  output logic [REQ_N-1:0]       req_ready,
  input  logic [1:0]             req_op0,
  input  logic [1:0]             req_op1,
  input  logic [DATA_W-1:0]      req_data0,
  input  logic [DATA_W-1:0]      req_data1,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_id,
  output logic                   busy,
  output logic [DATA_W-1:0]      calc_entrada,
  output logic [CALC_CODE_W-1:0] calc_codigo,
  input  logic [DATA_W-1:0]      calc_saida
);

  seq_state_e               state_q, state_d;
  calc_op_e                 op_q, op_d;
  logic                     id_q, id_d;
  logic [CALC_CODE_W-1:0]   calc_codigo_q, calc_codigo_d;
  logic [DATA_W-1:0]        calc_entrada_q, calc_entrada_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]        rsp_data_q, rsp_data_d;
  logic                     rsp_id_q, rsp_id_d;

  logic [REQ_N-1:0]         grant_c;
  logic [1:0]               sel_op_c;
  logic [DATA_W-1:0]        sel_data_c;

  calc_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .grant_en (state_q == ST_IDLE),
    .grant_c  (grant_c)
  );

  // Winner's command (only meaningful when a grant is present).
  assign sel_op_c   = grant_c[1] ? req_op1   : req_op0;
  assign sel_data_c = grant_c[1] ? req_data1 : req_data0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    id_d           = id_q;
    calc_codigo_d  = HOLD_CODE;
    calc_entrada_d = calc_entrada_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_id_d       = rsp_id_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|grant_c) begin
          op_d           = calc_op_e'(sel_op_c);
          id_d           = grant_c[1];
          calc_codigo_d  = {1'b0, sel_op_c};
          calc_entrada_d = sel_data_c;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Calculator samples the code at this edge; code drops back to hold.
        state_d = op_has_rsp(op_q) ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        rsp_data_d  = calc_saida;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_SHOW_IN;
      id_q           <= 1'b0;
      calc_codigo_q  <= HOLD_CODE;
      calc_entrada_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_id_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      id_q           <= id_d;
      calc_codigo_q  <= calc_codigo_d;
      calc_entrada_q <= calc_entrada_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_id_q       <= rsp_id_d;
    end
  end

  assign req_ready    = grant_c;
  assign busy         = (state_q != ST_IDLE);
  assign calc_codigo  = calc_codigo_q;
  assign calc_entrada = calc_entrada_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;

endmodule

// File: tb/tb_calc_seq_arbiter.sv
// Directed self-checking bench for calc_seq_arbiter with a behavioural
// accumulator calculator (reset = ~rst_n). Expected grant orders and
// accumulator values depend on CALC_SEQ_RR_EN.
module tb_calc_seq_arbiter;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_op0, req_op1;
  logic [DW-1:0] req_data0, req_data1;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;
  logic          busy;
  logic [DW-1:0] calc_entrada;
  logic [2:0]    calc_codigo;
  logic [DW-1:0] calc_saida;

  logic [DW-1:0] acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_seq_arbiter #(.DATA_W(DW), .HOLD_CODE(3'b111)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op0      (req_op0),
    .req_op1      (req_op1),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .busy         (busy),
    .calc_entrada (calc_entrada),
    .calc_codigo  (calc_codigo),
    .calc_saida   (calc_saida)
  );

  // Calculator: 0 show input, 1 add, 2 sub, 3 show accumulator, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      calc_saida <= '0;
    end else begin
      case (calc_codigo)
        3'd0:    calc_saida <= calc_entrada;
        3'd1:    acc        <= acc + calc_entrada;
        3'd2:    acc        <= acc - calc_entrada;
        3'd3:    calc_saida <= acc;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a command from requester r and wait (bounded) for its grant.
  // Returns in the ISSUE cycle with the request withdrawn; waited = cycles
  // spent before the grant.
  task automatic issue(input int r, input logic [1:0] op, input logic [DW-1:0] d,
                       output int waited);
    int n = 0;
    if (r == 0) begin req_op0 = op; req_data0 = d; req_valid[0] = 1'b1; end
    else        begin req_op1 = op; req_data1 = d; req_valid[1] = 1'b1; end
    #1;
    while (req_ready[r] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("grant_seen", 32'(n < 20), 32'd1);
    waited = n;
    step();
    req_valid[r] = 1'b0;
    chk("issue_code", 32'(calc_codigo), 32'({1'b0, op}));
    chk("issue_operand", 32'(calc_entrada), 32'(d));
    chk("issue_ready_low", 32'(req_ready), 32'd0);
  endtask

  // Display command with rsp_ready already high: response on 3rd cycle.
  task automatic show(input int r, input logic [1:0] op, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_data);
    int w;
    issue(r, op, d, w);
    chk("show_issue_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("show_wait_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("show_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("show_rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("show_rsp_id", 32'(rsp_id), 32'(r));
    step();
    chk("show_done_valid", 32'(rsp_valid), 32'd0);
    chk("show_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    logic [1:0] exp_gnt [4];
    logic [DW-1:0] exp_acc;

`ifdef CALC_SEQ_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_acc = 8'd4;   // 254 + 1 + 2 + 1 + 2
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b10};
    exp_acc = 8'd3;   // 254 + 1 + 1 + 1 + 2
`endif

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req_op0 = 2'd0; req_op1 = 2'd0; req_data0 = '0; req_data1 = '0;
    step(); step();

    // Reset values.
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code", 32'(calc_codigo), 32'h7);
    chk("rst_operand", 32'(calc_entrada), 32'd0);
    rst_n = 1'b1;
    step();

    // r0: ADD 5, ADD 3 back-to-back (accept every 2 cycles), SHOW_ACC -> 8.
    issue(0, 2'd1, 8'd5, w);
    chk("add5_wait", 32'(w), 32'd0);
    issue(0, 2'd1, 8'd3, w);
    chk("add3_throughput_wait", 32'(w), 32'd1);
    show(0, 2'd3, 8'd0, 8'd8);

    // r1: SUB 10 wraps to 254.
    issue(1, 2'd2, 8'd10, w);
    step();
    show(1, 2'd3, 8'd0, 8'd254);

    // Both valid: r0 ADD 1, r1 ADD 2; r0 dropped before the 4th grant.
    req_op0 = 2'd1; req_data0 = 8'd1; req_op1 = 2'd1; req_data1 = 8'd2;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin req_valid[0] = 1'b0; #1; end
      chk($sformatf("arb_grant%0d", k), 32'(req_ready), 32'(exp_gnt[k]));
      step();
      if (k == 3) req_valid[1] = 1'b0;
      #1;
      chk($sformatf("arb_issue_ready%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("arb_code%0d", k), 32'(calc_codigo), 32'd1);
      step();
    end
    show(0, 2'd3, 8'd0, exp_acc);

    // SHOW_IN 0x5A with rsp_ready low; r1 waits behind the response.
    rsp_ready = 1'b0;
    issue(0, 2'd0, 8'h5A, w);
    req_op1 = 2'd0; req_data1 = 8'h33; req_valid[1] = 1'b1;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_data%0d", k), 32'(rsp_data), 32'h5A);
      chk($sformatf("hold_ready%0d", k), 32'(req_ready), 32'd0);
      if (k < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    chk("hold_released", 32'(rsp_valid), 32'd0);
    chk("hold_r1_grant", 32'(req_ready), 32'b10);
    show(1, 2'd0, 8'h33, 8'h33);

    // Ten idle cycles: code held, accumulator untouched.
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("idle_code%0d", k), 32'(calc_codigo), 32'h7);
    end
    chk("idle_busy", 32'(busy), 32'd0);
    show(0, 2'd3, 8'd0, exp_acc);

    // Reset during WAIT of SHOW_ACC: response discarded.
    issue(0, 2'd3, 8'd0, w);
    step();
    chk("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_code", 32'(calc_codigo), 32'h7);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rstw_after_valid%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("rstw_after_busy%0d", k), 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
